// File: rtl/logic_block.sv
// Configurable logic block: a 4-input LUT with an optional output flop,
// programmed through a serial, daisy-chainable configuration shift register.
module logic_block #(
  parameter int CFG_BITS = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in0,
  input  logic in1,
  input  logic in2,
  input  logic in3,
  input  logic cfg_en,
  input  logic cfg_in,
  output logic cfg_out,
  output logic cfg_done,
  output logic cfg_err,
  output logic out
);

  typedef enum logic {IDLE, LOAD} state_t;

  localparam int USE_FF_BIT = 16;
  localparam int FF_INIT_BIT = CFG_BITS - 1;

  state_t              state_q, state_d;
  logic [CFG_BITS-1:0] sr_q, sr_d;
  logic [CFG_BITS-1:0] act_q, act_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                configured_q, configured_d;
  logic                ff_q, ff_d;
  logic                cfg_err_q, cfg_err_d;
  logic                cfg_done_q, cfg_done_d;

  logic [3:0]  lut_idx;
  logic [15:0] lut_table;
  logic        lut;

  assign lut_idx   = {in3, in2, in1, in0};
  assign lut_table = act_q[15:0];
  assign lut       = lut_table[lut_idx];

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    act_d        = act_q;
    cnt_d        = cnt_q;
    configured_d = configured_q;
    // The old configuration keeps running (flop included) until a commit.
    ff_d         = lut;
    cfg_err_d    = cfg_err_q;
    cfg_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_en) begin
          sr_d    = {sr_q[CFG_BITS-2:0], cfg_in};
          cnt_d   = 5'd1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cfg_en) begin
          sr_d  = {sr_q[CFG_BITS-2:0], cfg_in};
          cnt_d = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
        end else begin
          state_d = IDLE;
          if (cnt_q == 5'(CFG_BITS)) begin
            act_d        = sr_q;
            configured_d = 1'b1;
            ff_d         = sr_q[FF_INIT_BIT];
            cfg_done_d   = 1'b1;
            cfg_err_d    = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      act_q        <= '0;
      cnt_q        <= '0;
      configured_q <= 1'b0;
      ff_q         <= 1'b0;
      cfg_err_q    <= 1'b0;
      cfg_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      act_q        <= act_d;
      cnt_q        <= cnt_d;
      configured_q <= configured_d;
      ff_q         <= ff_d;
      cfg_err_q    <= cfg_err_d;
      cfg_done_q   <= cfg_done_d;
    end
  end

  assign cfg_out  = sr_q[CFG_BITS-1];
  assign cfg_done = cfg_done_q;
  assign cfg_err  = cfg_err_q;
  assign out      = configured_q & (act_q[USE_FF_BIT] ? ff_q : lut);

endmodule

// File: tb/tb_logic_block.sv
// Directed bench for logic_block: two instances chained through cfg_out so the
// daisy-chain path can be exercised alongside the single-block behaviour.
module tb_logic_block;

  logic clk;
  logic rst_n;
  logic in0, in1, in2, in3;
  logic cfg_en_a, cfg_en_b, cfg_in_a;
  logic cfg_out_a, cfg_done_a, cfg_err_a, out_a;
  logic cfg_out_b, cfg_done_b, cfg_err_b, out_b;

  int checks = 0;
  int errors = 0;

  localparam logic [17:0] F_AND4 = 18'h08000;
  localparam logic [17:0] F_ALT  = 18'h3AAAA;
  localparam logic [17:0] F_OR4  = 18'h0FFFE;

  logic_block #(.CFG_BITS(18)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .cfg_en(cfg_en_a), .cfg_in(cfg_in_a),
    .cfg_out(cfg_out_a), .cfg_done(cfg_done_a), .cfg_err(cfg_err_a), .out(out_a)
  );

  logic_block #(.CFG_BITS(18)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .cfg_en(cfg_en_b), .cfg_in(cfg_out_a),
    .cfg_out(cfg_out_b), .cfg_done(cfg_done_b), .cfg_err(cfg_err_b), .out(out_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] v);
    {in3, in2, in1, in0} = v;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shifts n bits of data (MSB of the n-bit field first), then closes the window.
  task automatic shift_bits(input logic [63:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_en_a = 1'b1;
      cfg_in_a = data[n-1-i];
      tick();
    end
    cfg_en_a = 1'b0;
    cfg_in_a = 1'b0;
  endtask

  task automatic check_and4(input string tag);
    set_in(4'b1111); check({tag, "_1111"}, 32'(out_a), 32'd1);
    set_in(4'b1110); check({tag, "_1110"}, 32'(out_a), 32'd0);
    set_in(4'b0111); check({tag, "_0111"}, 32'(out_a), 32'd0);
  endtask

  initial begin
    logic prev;
    rst_n = 1'b0;
    cfg_en_a = 1'b0; cfg_en_b = 1'b0; cfg_in_a = 1'b0;
    {in3, in2, in1, in0} = 4'b1111;
    tick(); tick();

    // reset state
    check("rst_out", 32'(out_a), 32'd0);
    check("rst_cfg_out", 32'(cfg_out_a), 32'd0);
    check("rst_done", 32'(cfg_done_a), 32'd0);
    check("rst_err", 32'(cfg_err_a), 32'd0);
    check("rst_out_b", 32'(out_b), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    check("unconfigured_out", 32'(out_a), 32'd0);

    // AND4 load
    shift_bits(64'(F_AND4), 18);
    check("and4_no_early_done", 32'(cfg_done_a), 32'd0);
    tick();
    check("and4_done", 32'(cfg_done_a), 32'd1);
    check("and4_err", 32'(cfg_err_a), 32'd0);
    tick();
    check("and4_done_pulse", 32'(cfg_done_a), 32'd0);
    for (int v = 0; v < 16; v++) begin
      set_in(4'(v));
      check($sformatf("and4_tt_%0d", v), 32'(out_a), (v == 15) ? 32'd1 : 32'd0);
    end

    // short frame keeps AND4 and raises cfg_err
    shift_bits(64'(F_OR4), 17);
    tick();
    check("short_err", 32'(cfg_err_a), 32'd1);
    check("short_no_done", 32'(cfg_done_a), 32'd0);
    check_and4("short_keep");
    shift_bits(64'(F_AND4), 18);
    check("reload_err_still_set", 32'(cfg_err_a), 32'd1);
    tick();
    check("reload_done", 32'(cfg_done_a), 32'd1);
    check("reload_err_clear", 32'(cfg_err_a), 32'd0);

    // registered path: LUT = in0, flop initialised to 1
    set_in(4'b0000);
    shift_bits(64'(F_ALT), 18);
    tick();
    check("ff_done", 32'(cfg_done_a), 32'd1);
    check("ff_init_out", 32'(out_a), 32'd1);
    prev = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic b;
      b = (i == 1 || i == 2 || i == 4) ? 1'b1 : 1'b0;
      set_in({3'($urandom_range(0, 7)), b});
      check($sformatf("ff_hold_%0d", i), 32'(out_a), 32'(prev));
      tick();
      check($sformatf("ff_follow_%0d", i), 32'(out_a), 32'(b));
      prev = b;
    end

    // the flop keeps following in0 while a new frame is shifting in
    for (int i = 0; i < 18; i++) begin
      logic b;
      b = 1'(i % 3 == 0);
      cfg_en_a = 1'b1;
      cfg_in_a = F_AND4[17-i];
      {in3, in2, in1, in0} = {3'b000, b};
      tick();
      check($sformatf("reload_ff_%0d", i), 32'(out_a), 32'(b));
    end
    cfg_en_a = 1'b0;
    cfg_in_a = 1'b0;
    tick();
    check("ff_to_and4_done", 32'(cfg_done_a), 32'd1);
    check_and4("ff_to_and4");

    // over-long window saturates the counter and is rejected
    shift_bits(64'h00_AB_CDEF_1234, 40);
    check("long_cnt_sat", 32'(u_a.cnt_q), 32'd31);
    tick();
    check("long_err", 32'(cfg_err_a), 32'd1);
    check("long_no_done", 32'(cfg_done_a), 32'd0);
    check_and4("long_keep");

    // reset in the middle of a frame
    for (int i = 0; i < 9; i++) begin
      cfg_en_a = 1'b1;
      cfg_in_a = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    set_in(4'b1111);
    check("midrst_out", 32'(out_a), 32'd0);
    check("midrst_err", 32'(cfg_err_a), 32'd0);
    check("midrst_cfg_out", 32'(cfg_out_a), 32'd0);
    tick();
    check("midrst_held_out", 32'(out_a), 32'd0);
    check("midrst_no_done", 32'(cfg_done_a), 32'd0);
    cfg_en_a = 1'b0;
    cfg_in_a = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_out", 32'(out_a), 32'd0);
    shift_bits(64'(F_AND4), 18);
    tick();
    check("post_rst_done", 32'(cfg_done_a), 32'd1);
    check_and4("post_rst");

    // daisy chain: A's frame for B first, then both shift together
    shift_bits(64'(F_AND4), 18);
    tick();
    for (int i = 0; i < 18; i++) begin
      cfg_en_a = 1'b1;
      cfg_en_b = 1'b1;
      cfg_in_a = F_OR4[17-i];
      #1;
      check($sformatf("chain_cfg_out_%0d", i), 32'(cfg_out_a), 32'(F_AND4[17-i]));
      tick();
    end
    cfg_en_a = 1'b0;
    cfg_en_b = 1'b0;
    cfg_in_a = 1'b0;
    tick();
    check("chain_done_a", 32'(cfg_done_a), 32'd1);
    check("chain_done_b", 32'(cfg_done_b), 32'd1);
    check("chain_err_b", 32'(cfg_err_b), 32'd0);
    set_in(4'b0000);
    check("chain_a_0000", 32'(out_a), 32'd0);
    check("chain_b_0000", 32'(out_b), 32'd0);
    set_in(4'b0100);
    check("chain_a_0100", 32'(out_a), 32'd1);
    check("chain_b_0100", 32'(out_b), 32'd0);
    set_in(4'b1111);
    check("chain_a_1111", 32'(out_a), 32'd1);
    check("chain_b_1111", 32'(out_b), 32'd1);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_block.md
LOGIC_BLOCK -- requirements
Module: logic_block

Interface
REQ-001 SHALL have parameter CFG_BITS, default 18, meaning config frame length: 16 LUT bits plus use_ff plus ff_init; fixed, other values unsupported.
REQ-002 SHALL use one clock and an asynchronous, active-low reset; clk and rst_n are the only clock and reset ports.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports in0..in3  input  1 each  LUT inputs, driven by the block_out of the upstream connect boxes; index = {in3,in2,in1,in0}.
REQ-006 SHALL have port cfg_en  input  1  config load window; high = shift one bit per cycle.
REQ-007 SHALL have port cfg_in  input  1  serial config data, MSB of frame first.
REQ-008 SHALL have port cfg_out  output  1  serial daisy-chain output = MSB of shift register.
REQ-009 SHALL have port cfg_done  output  1  one-cycle pulse on successful commit.
REQ-010 SHALL have port cfg_err  output  1  sticky flag: last load window had wrong length.
REQ-011 SHALL have port out  output  1  block result, routed to the downstream tracks.

Function
REQ-012 SHALL hold an 18-bit shift register sr, an 18-bit active config act, a 5-bit bit counter cnt, a flag configured, a user flip-flop ff, and a state machine with states IDLE, LOAD.
REQ-013 SHALL, in IDLE with cfg_en=1, shift cfg_in into sr[0] (sr <= {sr[16:0],cfg_in}), set cnt=1 and enter LOAD.
REQ-014 SHALL, in LOAD with cfg_en=1, shift likewise and increment cnt, saturating at 31.
REQ-015 SHALL, in LOAD with cfg_en=0 and cnt==18, commit: act<=sr, configured<=1, ff<=sr[17], cfg_done=1 for exactly that next cycle, cfg_err<=0, go IDLE.
REQ-016 SHALL, in LOAD with cfg_en=0 and cnt!=18, not commit: act, configured and ff unchanged, cfg_err<=1, no cfg_done, go IDLE.
REQ-017 SHALL drive cfg_out = sr[17] combinationally from the register, so it is a one-frame delay chain to the next block.
REQ-018 SHALL compute lut = act[{in3,in2,in1,in0}] combinationally, with act[15:0] the LUT table.
REQ-019 SHALL, when configured=1 and act[16]=0, drive out = lut (combinational path).
REQ-020 SHALL, when configured=1 and act[16]=1, drive out = ff, with ff <= lut on every clock edge except the commit edge.
REQ-021 SHALL drive out=0 while configured=0.
REQ-022 SHALL keep the previous act operating unchanged during a reload until commit, including ff updates.
REQ-023 SHALL NOT back-pressure: cfg_en may go high again on the cycle after it falls; that cycle is treated as IDLE with cfg_en=1.
REQ-024 SHALL NOT shift sr while cfg_en=0.

Reset
REQ-025 SHALL, on rst_n=0 and independent of clk, clear sr, act, cnt, configured, ff, cfg_err and cfg_done to 0 and set the state to IDLE.
REQ-026 SHALL hold out=0 and cfg_out=0 throughout reset.
REQ-027 SHALL, on reset assertion mid-LOAD, abandon the frame without commit and without cfg_err.
REQ-028 SHALL act on the first rising clk edge after rst_n deasserts.

Verification
REQ-029 SHALL test AND4: load frame 0x08000 (use_ff=0, LUT bit15=1) over 18 cycles, then drop cfg_en -> cfg_done pulses once; out=1 only for in=4'b1111; cfg_err=0.
REQ-030 SHALL test the registered path: load LUT=0xAAAA, use_ff=1, ff_init=1 -> out=1 right after commit; then out follows in0 with one cycle of delay.
REQ-031 SHALL test a short frame: a 17-bit window after a good AND4 load -> cfg_err=1, no cfg_done, AND4 behaviour retained; a following 18-bit load clears cfg_err.
REQ-032 SHALL test the daisy chain: 36 bits shifted through two chained blocks -> each commits its own 18-bit frame; cfg_out of the first block equals cfg_in delayed 18 cycles.
REQ-033 SHALL test reset mid-load: rst_n=0 at bit 9 -> out=0, configured=0, cfg_err=0; a subsequent full load works.
REQ-034 SHALL test an over-long frame: a 40-bit window -> cnt saturates at 31, cfg_err=1, no commit.
